sp_ram_tag_ctrl: RTL and testbench



---
 rtl/sp_ram_tag_ctrl.sv | 142 ++++++++++++++
 tb/tb_sp_ram_tag_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_tag_ctrl.sv
// Single-port tag memory with per-lane tag writes, req/gnt/rvalid access and a clearing sweep FSM.
// Optional per-lane even parity with err_o reporting is enabled by defining TAG_RAM_PARITY_EN.
module sp_ram_tag_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 1,
    parameter int NUM_WORDS  = 4096
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_i,
    output logic                                  gnt_o,
    input  logic [ADDR_WIDTH-1:0]                 addr_i,
    input  logic                                  we_i,
    input  logic [DATA_WIDTH/8-1:0]               be_i,
    input  logic [(DATA_WIDTH/8)*TAG_WIDTH-1:0]   wdata_i,
    output logic                                  rvalid_o,
    output logic [(DATA_WIDTH/8)*TAG_WIDTH-1:0]   rdata_o,
    input  logic                                  flush_i,
    output logic                                  busy_o,
    output logic                                  err_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int WORDS = NUM_WORDS / BYTES;
    localparam int IDXW  = ADDR_WIDTH - LSB;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TW    = BYTES * TAG_WIDTH;

    localparam logic [CW-1:0]   LAST    = CW'(WORDS - 1);
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [IDXW:0]   WORDS_L = (IDXW + 1)'(WORDS);

    localparam logic [0:0] SWEEP = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    logic [0:0]      state;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   mem [WORDS];
    logic [IDXW-1:0] idx;
    logic [CW-1:0]   sel;
    logic            in_range;
    logic [TW-1:0]   rd_word;

    assign idx      = addr_i[ADDR_WIDTH-1:LSB];
    assign sel      = idx[CW-1:0];
    assign in_range = ({1'b0, idx} < WORDS_L);
    assign rd_word  = mem[sel];
    assign gnt_o    = req_i & (state == IDLE) & ~flush_i;

    generate
        if (LSB > 0) begin : g_unused_lsb
            logic unused_addr_lsb;
            assign unused_addr_lsb = ^addr_i[LSB-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SWEEP;
            cnt    <= '0;
            busy_o <= 1'b1;
        end else begin
            case (state)
                SWEEP: begin
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    if (flush_i) begin
                        state  <= SWEEP;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef TAG_RAM_PARITY_EN
    logic [BYTES-1:0] par_mem [WORDS];
    logic [BYTES-1:0] par_bad;
    logic             err_q;

    always_comb begin
        par_bad = '0;
        for (int i = 0; i < BYTES; i++) begin
            par_bad[i] = (^rd_word[i*TAG_WIDTH +: TAG_WIDTH]) ^ par_mem[sel][i];
        end
    end
`endif

    // Sweep has priority; grants never happen outside IDLE, so the two writers never collide.
    always_ff @(posedge clk) begin
        if (!rst && state == SWEEP) begin
            mem[cnt] <= '0;
`ifdef TAG_RAM_PARITY_EN
            par_mem[cnt] <= '0;
`endif
        end else if (gnt_o && we_i && in_range) begin
            for (int i = 0; i < BYTES; i++) begin
                if (be_i[i]) begin
                    mem[sel][i*TAG_WIDTH +: TAG_WIDTH] <= wdata_i[i*TAG_WIDTH +: TAG_WIDTH];
`ifdef TAG_RAM_PARITY_EN
                    par_mem[sel][i] <= ^wdata_i[i*TAG_WIDTH +: TAG_WIDTH];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
`ifdef TAG_RAM_PARITY_EN
            err_q    <= 1'b0;
`endif
        end else begin
            rvalid_o <= gnt_o;
            if (gnt_o && !we_i) begin
                rdata_o <= in_range ? rd_word : '0;
            end
`ifdef TAG_RAM_PARITY_EN
            err_q <= gnt_o & ~we_i & in_range & (|par_bad);
`endif
        end
    end

`ifdef TAG_RAM_PARITY_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sp_ram_tag_ctrl.sv
// Directed self-checking bench for sp_ram_tag_ctrl with WORDS=16, TAG_WIDTH=2.
// Parity checks are included when TAG_RAM_PARITY_EN is defined.
module tb_sp_ram_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [11:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  wdata;
    logic        rvalid;
    logic [7:0]  rdata;
    logic        flush;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    sp_ram_tag_ctrl #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(32),
        .TAG_WIDTH (2),
        .NUM_WORDS (64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .gnt_o   (gnt),
        .addr_i  (addr),
        .we_i    (we),
        .be_i    (be),
        .wdata_i (wdata),
        .rvalid_o(rvalid),
        .rdata_o (rdata),
        .flush_i (flush),
        .busy_o  (busy),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    // One access: drive on the falling edge, sample grant mid-cycle and the response after the next rising edge.
    task automatic access(input logic w, input logic [11:0] a, input logic [3:0] b, input logic [7:0] d,
                          output logic g, output logic v, output logic [7:0] r, output logic e);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        #1 g = gnt;
        @(posedge clk);
        #1 v = rvalid; r = rdata; e = err;
        req = 1'b0; we = 1'b0;
    endtask

    // Must be called at a falling edge; counts falling-edge samples with busy high, bounded.
    task automatic count_busy(output int n, output logic g_seen, output logic g_after);
        n = 0; g_seen = 1'b0; g_after = 1'b0;
        req = 1'b1; we = 1'b0; addr = 12'h000;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (busy !== 1'b1) begin
                g_after = gnt;
                break;
            end
            n++;
            if (gnt !== 1'b0) g_seen = 1'b1;
            @(negedge clk);
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        int n; logic gs, ga, g, v, e; logic [7:0] r;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL reset_busy: got %b want 1", busy); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid: got %b want 0", rvalid); end
        total++; if (rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 00", rdata); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", err); end
        @(negedge clk);
        rst = 1'b0;
        count_busy(n, gs, ga);
        total++; if (n != 16) begin bad++; $display("[TB] FAIL reset_sweep_len: got %0d want 16", n); end
        total++; if (gs !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt_in_sweep: got %b want 0", gs); end
        total++; if (ga !== 1'b1) begin bad++; $display("[TB] FAIL reset_gnt_after: got %b want 1", ga); end
        for (int i = 0; i < 16; i++) begin
            access(1'b0, 12'(i * 4), 4'h0, 8'h00, g, v, r, e);
            total++; if (g !== 1'b1 || v !== 1'b1 || r !== 8'h00) begin
                bad++; $display("[TB] FAIL reset_clear_read idx=%0d: got gnt=%b rvalid=%b rdata=%h want 1 1 00", i, g, v, r);
            end
        end
    endtask

    task automatic test_write_read();
        logic g, v, e; logic [7:0] r;
        access(1'b1, 12'h008, 4'b1111, 8'hE4, g, v, r, e);
        total++; if (g !== 1'b1 || v !== 1'b1 || r !== 8'h00) begin
            bad++; $display("[TB] FAIL write_full: got gnt=%b rvalid=%b rdata=%h want 1 1 00", g, v, r);
        end
        access(1'b0, 12'h008, 4'b0000, 8'h00, g, v, r, e);
        total++; if (g !== 1'b1 || v !== 1'b1 || r !== 8'hE4 || e !== 1'b0) begin
            bad++; $display("[TB] FAIL read_full: got gnt=%b rvalid=%b rdata=%h err=%b want 1 1 e4 0", g, v, r, e);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 12'h008; be = 4'b0101; wdata = 8'hFF;
        #1;
        total++; if (gnt !== 1'b1) begin bad++; $display("[TB] FAIL b2b_gnt_write: got %b want 1", gnt); end
        @(posedge clk);
        #1;
        total++; if (rvalid !== 1'b1 || rdata !== 8'hE4) begin
            bad++; $display("[TB] FAIL b2b_rsp_write: got rvalid=%b rdata=%h want 1 e4", rvalid, rdata);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        total++; if (gnt !== 1'b1) begin bad++; $display("[TB] FAIL b2b_gnt_read: got %b want 1", gnt); end
        @(posedge clk);
        #1;
        total++; if (rvalid !== 1'b1 || rdata !== 8'hF7) begin
            bad++; $display("[TB] FAIL b2b_rsp_read: got rvalid=%b rdata=%h want 1 f7", rvalid, rdata);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        total++; if (rvalid !== 1'b0 || rdata !== 8'hF7) begin
            bad++; $display("[TB] FAIL b2b_idle_hold: got rvalid=%b rdata=%h want 0 f7", rvalid, rdata);
        end
    endtask

    task automatic test_flush();
        int n; logic gs, ga, g, v, e; logic [7:0] r;
        @(negedge clk);
        flush = 1'b1; req = 1'b1; we = 1'b0; addr = 12'h008;
        #1;
        total++; if (gnt !== 1'b0) begin bad++; $display("[TB] FAIL flush_no_gnt: got %b want 0", gnt); end
        @(negedge clk);
        flush = 1'b0;
        count_busy(n, gs, ga);
        total++; if (n != 16) begin bad++; $display("[TB] FAIL flush_sweep_len: got %0d want 16", n); end
        total++; if (gs !== 1'b0) begin bad++; $display("[TB] FAIL flush_gnt_in_sweep: got %b want 0", gs); end
        access(1'b0, 12'h008, 4'h0, 8'h00, g, v, r, e);
        total++; if (g !== 1'b1 || r !== 8'h00) begin
            bad++; $display("[TB] FAIL flush_cleared: got gnt=%b rdata=%h want 1 00", g, r);
        end
    endtask

    task automatic test_out_of_range();
        logic g, v, e; logic [7:0] r;
        access(1'b1, 12'h000, 4'hF, 8'hA5, g, v, r, e);
        access(1'b1, 12'h03C, 4'hF, 8'h5A, g, v, r, e);
        access(1'b0, 12'h03C, 4'h0, 8'h00, g, v, r, e);
        total++; if (r !== 8'h5A) begin bad++; $display("[TB] FAIL oor_setup_read: got %h want 5a", r); end
        access(1'b0, 12'h040, 4'h0, 8'h00, g, v, r, e);
        total++; if (g !== 1'b1 || v !== 1'b1 || r !== 8'h00) begin
            bad++; $display("[TB] FAIL oor_read: got gnt=%b rvalid=%b rdata=%h want 1 1 00", g, v, r);
        end
        access(1'b1, 12'h040, 4'hF, 8'hFF, g, v, r, e);
        total++; if (g !== 1'b1) begin bad++; $display("[TB] FAIL oor_write_gnt: got %b want 1", g); end
        access(1'b1, 12'hFFC, 4'hF, 8'hFF, g, v, r, e);
        access(1'b0, 12'h000, 4'h0, 8'h00, g, v, r, e);
        total++; if (r !== 8'hA5) begin bad++; $display("[TB] FAIL oor_entry0: got %h want a5", r); end
        access(1'b0, 12'h03C, 4'h0, 8'h00, g, v, r, e);
        total++; if (r !== 8'h5A) begin bad++; $display("[TB] FAIL oor_entry15: got %h want 5a", r); end
        access(1'b0, 12'h004, 4'h0, 8'h00, g, v, r, e);
        total++; if (r !== 8'h00) begin bad++; $display("[TB] FAIL oor_entry1: got %h want 00", r); end
    endtask

    task automatic test_reset_mid_sweep();
        int n; logic gs, ga, g, v, e; logic [7:0] r;
        access(1'b0, 12'h000, 4'h0, 8'h00, g, v, r, e);
        total++; if (r !== 8'hA5) begin bad++; $display("[TB] FAIL rst_setup_read: got %h want a5", r); end
        @(negedge clk);
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 12'h000;
        @(posedge clk);
        #1;
        total++; if (rvalid !== 1'b0 || rdata !== 8'h00) begin
            bad++; $display("[TB] FAIL rst_pending_rvalid: got rvalid=%b rdata=%h want 0 00", rvalid, rdata);
        end
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_busy: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(n, gs, ga);
        total++; if (n != 16) begin bad++; $display("[TB] FAIL rst_restart_len: got %0d want 16", n); end
        access(1'b0, 12'h000, 4'h0, 8'h00, g, v, r, e);
        total++; if (g !== 1'b1 || r !== 8'h00) begin
            bad++; $display("[TB] FAIL rst_sweep_cleared: got gnt=%b rdata=%h want 1 00", g, r);
        end
    endtask

`ifdef TAG_RAM_PARITY_EN
    task automatic test_parity();
        logic g, v, e; logic [7:0] r;
        access(1'b1, 12'h008, 4'hF, 8'hE4, g, v, r, e);
        access(1'b0, 12'h008, 4'h0, 8'h00, g, v, r, e);
        total++; if (e !== 1'b0 || r !== 8'hE4) begin
            bad++; $display("[TB] FAIL parity_clean: got err=%b rdata=%h want 0 e4", e, r);
        end
        @(negedge clk);
        dut.par_mem[2][1] = ~dut.par_mem[2][1];
        access(1'b0, 12'h008, 4'h0, 8'h00, g, v, r, e);
        total++; if (v !== 1'b1 || e !== 1'b1) begin
            bad++; $display("[TB] FAIL parity_err: got rvalid=%b err=%b want 1 1", v, e);
        end
        @(posedge clk);
        #1;
        total++; if (rvalid !== 1'b0 || err !== 1'b0) begin
            bad++; $display("[TB] FAIL parity_err_clear: got rvalid=%b err=%b want 0 0", rvalid, err);
        end
        access(1'b0, 12'h000, 4'h0, 8'h00, g, v, r, e);
        total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL parity_other_entry: got %b want 0", e); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_flush();
        test_out_of_range();
        test_reset_mid_sweep();
`ifdef TAG_RAM_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
